// File: rtl/scalar_lsu.sv
// Scalar load/store unit: one op in flight, single-beat memory access, load result held for writeback.
// Optional SCALAR_LSU_ALIGN_CHECK_EN: misaligned ops are dropped and flagged on misalign_fault.
module scalar_lsu #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int REG_W  = 5
) (
    input  logic              CLK,
    input  logic              nRST,
    input  logic              issue_valid,
    output logic              issue_ready,
    input  logic              issue_is_store,
    input  logic [ADDR_W-1:0] issue_addr,
    input  logic [DATA_W-1:0] issue_wdata,
    input  logic [REG_W-1:0]  issue_rd,
    output logic              dmem_req,
    output logic              dmem_wen,
    output logic [ADDR_W-1:0] dmem_addr,
    output logic [DATA_W-1:0] dmem_wdata,
    input  logic              dmem_ready,
    input  logic [DATA_W-1:0] dmem_rdata,
    output logic              load_ready,
    output logic [REG_W-1:0]  reg_sel_load,
    output logic [DATA_W-1:0] dmemload,
    input  logic              load_done,
    output logic              store_done,
    output logic              misalign_fault
);
    typedef enum logic [1:0] {IDLE, REQ, WB} state_t;

    state_t             state, state_nxt;
    logic               run;
    logic               is_store_q;
    logic [ADDR_W-1:0]  addr_q;
    logic [DATA_W-1:0]  wdata_q;
    logic [REG_W-1:0]   rd_q;
    logic               accept;
    logic               mem_done;
    logic               misalign;

    // run holds issue_ready low while reset is asserted so every output reads 0 in reset
    assign issue_ready = run && (state == IDLE);
    assign dmem_req    = (state == REQ);
    assign load_ready  = (state == WB);
    assign dmem_wen    = is_store_q;
    assign dmem_addr   = addr_q;
    assign dmem_wdata  = wdata_q;

    assign accept   = issue_ready && issue_valid;
    assign mem_done = (state == REQ) && dmem_ready;

`ifdef SCALAR_LSU_ALIGN_CHECK_EN
    logic fault_q;
    assign misalign       = (issue_addr[1:0] != 2'b00);
    assign misalign_fault = fault_q;

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) fault_q <= 1'b0;
        else       fault_q <= accept && misalign;
    end
`else
    assign misalign       = 1'b0;
    assign misalign_fault = 1'b0;
`endif

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept && !misalign) state_nxt = REQ;
            REQ:     if (dmem_ready) state_nxt = is_store_q ? IDLE : WB;
            WB:      if (load_done) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state        <= IDLE;
            run          <= 1'b0;
            is_store_q   <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= '0;
            rd_q         <= '0;
            dmemload     <= '0;
            reg_sel_load <= '0;
            store_done   <= 1'b0;
        end else begin
            state      <= state_nxt;
            run        <= 1'b1;
            store_done <= mem_done && is_store_q;
            if (accept) begin
                is_store_q <= issue_is_store;
                addr_q     <= issue_addr;
                wdata_q    <= issue_wdata;
                rd_q       <= issue_rd;
            end
            if (mem_done && !is_store_q) begin
                dmemload     <= dmem_rdata;
                reg_sel_load <= rd_q;
            end
        end
    end
endmodule

// File: tb/tb_scalar_lsu.sv
// Bench for scalar_lsu: directed plan steps plus random ops against a word-memory scoreboard.
module tb_scalar_lsu;
    logic        CLK = 0;
    logic        nRST = 0;
    logic        issue_valid = 0, issue_ready, issue_is_store = 0;
    logic [31:0] issue_addr = 0, issue_wdata = 0;
    logic [4:0]  issue_rd = 0;
    logic        dmem_req, dmem_wen, dmem_ready = 0;
    logic [31:0] dmem_addr, dmem_wdata, dmem_rdata = 0;
    logic        load_ready, load_done = 0, store_done, misalign_fault;
    logic [4:0]  reg_sel_load;
    logic [31:0] dmemload;

    int errors = 0;
    int checks = 0;
    logic [31:0] mem [logic [31:0]];

    scalar_lsu dut (
        .CLK(CLK), .nRST(nRST),
        .issue_valid(issue_valid), .issue_ready(issue_ready), .issue_is_store(issue_is_store),
        .issue_addr(issue_addr), .issue_wdata(issue_wdata), .issue_rd(issue_rd),
        .dmem_req(dmem_req), .dmem_wen(dmem_wen), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
        .dmem_ready(dmem_ready), .dmem_rdata(dmem_rdata),
        .load_ready(load_ready), .reg_sel_load(reg_sel_load), .dmemload(dmemload),
        .load_done(load_done), .store_done(store_done), .misalign_fault(misalign_fault)
    );

    always #5 CLK = ~CLK;

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One complete op: memory answers after w wait cycles, writeback acks d cycles after load_ready.
    task automatic run_op(input bit st, input logic [31:0] a, input logic [31:0] wd,
                          input logic [4:0] rd, input int w, input int d, input bit spur);
        logic [31:0] rdat;
        int reqc;
        issue_valid = 1; issue_is_store = st; issue_addr = a; issue_wdata = wd; issue_rd = rd;
        chk("issue_ready_idle", issue_ready, 1);
        step();
        issue_valid = 0; issue_addr = $urandom; issue_wdata = $urandom; issue_rd = 5'($urandom);
        rdat = mem.exists(a) ? mem[a] : $urandom;
        reqc = 0;
        for (int i = 0; i <= w; i++) begin
            if (dmem_req === 1'b1) reqc++;
            chk("req_addr", dmem_addr, a);
            chk("req_wen", dmem_wen, st);
            if (st) chk("req_wdata", dmem_wdata, wd);
            chk("busy_issue_ready", issue_ready, 0);
            chk("busy_load_ready", load_ready, 0);
            if (i == w) begin
                dmem_ready = 1; dmem_rdata = rdat;
            end else begin
                load_done = spur;
            end
            step();
            dmem_ready = 0; load_done = 0; dmem_rdata = $urandom;
        end
        chk("req_cycles", reqc, w + 1);
        chk("req_drop", dmem_req, 0);
        if (st) begin
            mem[a] = wd;
            chk("store_done", store_done, 1);
            chk("store_issue_ready", issue_ready, 1);
            chk("store_no_lr", load_ready, 0);
        end else begin
            mem[a] = rdat;
            chk("load_no_sd", store_done, 0);
            for (int j = 0; j <= d; j++) begin
                chk("wb_load_ready", load_ready, 1);
                chk("wb_rd", reg_sel_load, rd);
                chk("wb_data", dmemload, rdat);
                chk("wb_issue_ready", issue_ready, 0);
                if (j == d) load_done = 1;
                step();
                load_done = 0;
            end
            chk("wb_exit_lr", load_ready, 0);
            chk("wb_exit_ir", issue_ready, 1);
        end
    endtask

    initial begin
        logic [31:0] ra;
        // reset state: everything 0, including issue_ready
        #2;
        chk("rst_issue_ready", issue_ready, 0);
        chk("rst_dmem_req", dmem_req, 0);
        chk("rst_load_ready", load_ready, 0);
        chk("rst_store_done", store_done, 0);
        chk("rst_misalign", misalign_fault, 0);
        chk("rst_dmem_addr", dmem_addr, 0);
        chk("rst_dmemload", dmemload, 0);
        step();
        nRST = 1;
        step();
        chk("post_rst_ready", issue_ready, 1);

        // load rd=7 @0x100, 3 wait cycles, ack 2 cycles after load_ready
        mem[32'h100] = 32'hDEADBEEF;
        run_op(0, 32'h100, 32'h0, 5'd7, 3, 2, 0);

        // store with zero-wait memory, next op issued immediately, then single-pulse check
        run_op(1, 32'h40, 32'h12345678, 5'd0, 0, 0, 0);
        run_op(0, 32'h40, 32'h0, 5'd3, 0, 0, 0);
        run_op(1, 32'h44, 32'hCAFEF00D, 5'd0, 0, 0, 0);
        step();
        chk("store_pulse_single", store_done, 0);

        // back-to-back: load then store with issue_valid held
        issue_valid = 1; issue_is_store = 0; issue_addr = 32'h44; issue_rd = 5'd9;
        step();
        issue_is_store = 1; issue_addr = 32'h80; issue_wdata = 32'h55AA55AA;
        chk("b2b_req", dmem_req, 1);
        chk("b2b_hold_ir", issue_ready, 0);
        step();
        chk("b2b_addr_stable", dmem_addr, 32'h44);
        dmem_ready = 1; dmem_rdata = mem[32'h44];
        step();
        dmem_ready = 0;
        chk("b2b_wb", load_ready, 1);
        chk("b2b_wb_ir", issue_ready, 0);
        chk("b2b_wb_data", dmemload, 32'hCAFEF00D);
        load_done = 1;
        step();
        load_done = 0;
        chk("b2b_exit_ir", issue_ready, 1);
        step();
        issue_valid = 0;
        chk("b2b_store_req", dmem_req, 1);
        chk("b2b_store_addr", dmem_addr, 32'h80);
        chk("b2b_store_wen", dmem_wen, 1);
        dmem_ready = 1;
        step();
        dmem_ready = 0;
        mem[32'h80] = 32'h55AA55AA;
        chk("b2b_store_done", store_done, 1);

        // spurious dmem_ready in IDLE, spurious load_done in REQ
        dmem_ready = 1;
        step();
        dmem_ready = 0;
        chk("spur_idle_req", dmem_req, 0);
        chk("spur_idle_ir", issue_ready, 1);
        chk("spur_idle_lr", load_ready, 0);
        chk("spur_idle_sd", store_done, 0);
        run_op(0, 32'h80, 32'h0, 5'd12, 2, 1, 1);

        // reset while a load result is pending
        issue_valid = 1; issue_is_store = 0; issue_addr = 32'h100; issue_rd = 5'd21;
        step();
        issue_valid = 0;
        dmem_ready = 1; dmem_rdata = 32'h0BADF00D;
        step();
        dmem_ready = 0;
        chk("pre_rst_lr", load_ready, 1);
        #2 nRST = 0;
        #1;
        chk("arst_lr", load_ready, 0);
        chk("arst_rd", reg_sel_load, 0);
        chk("arst_data", dmemload, 0);
        chk("arst_ir", issue_ready, 0);
        chk("arst_addr", dmem_addr, 0);
        @(posedge CLK);
        #2 nRST = 1;
        step();
        chk("arst_release_ir", issue_ready, 1);
        chk("arst_release_lr", load_ready, 0);

`ifdef SCALAR_LSU_ALIGN_CHECK_EN
        issue_valid = 1; issue_is_store = 0; issue_addr = 32'h102; issue_rd = 5'd4;
        step();
        issue_valid = 0;
        chk("mis_fault", misalign_fault, 1);
        chk("mis_no_req", dmem_req, 0);
        chk("mis_ir", issue_ready, 1);
        chk("mis_no_lr", load_ready, 0);
        step();
        chk("mis_fault_pulse", misalign_fault, 0);
        chk("mis_no_req2", dmem_req, 0);
        chk("mis_no_lr2", load_ready, 0);
`else
        run_op(0, 32'h102, 32'h0, 5'd4, 1, 0, 0);
        chk("no_align_fault", misalign_fault, 0);
`endif

        // random ops against the memory scoreboard
        for (int n = 0; n < 60; n++) begin
            ra = 32'h1000 + {26'd0, 4'($urandom_range(0, 15)), 2'b00};
`ifndef SCALAR_LSU_ALIGN_CHECK_EN
            ra[1:0] = 2'($urandom);
`endif
            if ($urandom_range(0, 3) == 0) begin
                dmem_ready = 1;
                step();
                dmem_ready = 0;
                chk("rnd_idle_req", dmem_req, 0);
                chk("rnd_idle_ir", issue_ready, 1);
                chk("rnd_idle_sd", store_done, 0);
            end
            run_op(1'($urandom), ra, $urandom, 5'($urandom), $urandom_range(0, 3),
                   $urandom_range(0, 3), 1'($urandom));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
